ac_alu_unit: RTL and testbench

- Accumulator/ALU datapath stage directly downstream of the control unit (cu).
- Receives decoded operation codes plus a 16-bit operand (cu_data from cu, driven here into dr_data) over a valid/ready handshake.
- Holds the AC register and E (carry/link) flag and executes basic-computer register-reference and memory-reference ALU operations.
- Drives ac_data back to cu and exposes zero/negative status for skip instructions.

---
 rtl/ac_alu_unit_if.sv | 36 +++
 rtl/ac_alu_unit.sv | 170 +++++++++++++++++
 tb/tb_ac_alu_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ac_alu_unit_if.sv
// ac_alu_unit_if: operation handshake and status bundle between the control
// unit (cu, master) and the accumulator/ALU stage (ac_alu_unit, slave).
//   op_valid  cu -> unit   operation presented
//   op_ready  unit -> cu   unit accepts an operation this cycle
//   opcode    cu -> unit   4-bit operation select
//   dr_data   cu -> unit   WIDTH-bit memory operand (DR)
//   ac_data   unit -> cu   current AC value
//   e_flag    unit -> cu   current E (carry/link) flag
//   ac_zero   unit -> cu   AC == 0
//   ac_neg    unit -> cu   AC sign bit
//   busy      unit -> cu   unit is not idle
//   done      unit -> cu   one-cycle pulse when a result is written
interface ac_alu_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] dr_data;
  logic [WIDTH-1:0] ac_data;
  logic             e_flag;
  logic             ac_zero;
  logic             ac_neg;
  logic             busy;
  logic             done;

  modport master (
    output op_valid, opcode, dr_data,
    input  op_ready, ac_data, e_flag, ac_zero, ac_neg, busy, done
  );

  modport slave (
    input  op_valid, opcode, dr_data,
    output op_ready, ac_data, e_flag, ac_zero, ac_neg, busy, done
  );
endinterface

// File: rtl/ac_alu_unit.sv
// ac_alu_unit: accumulator/ALU stage of the basic computer. Holds AC and the
// E (carry/link) flag and executes register- and memory-reference ALU ops
// handed over by the control unit on a valid/ready handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   en     global enable; 0 freezes all state
//   bus    ac_alu_unit_if.slave (handshake, operand, AC/E/status outputs)
// Optional feature: define AC_MUL_EN to add opcode 11 (unsigned shift-add
// multiply over MUL_CYCLES iterations). Without it opcode 11 is a NOP.
module ac_alu_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  ac_alu_unit_if.slave bus
);

  if (MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("ac_alu_unit: MUL_CYCLES must equal WIDTH");
  end

  localparam logic [3:0] OpAnd = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpLda = 4'd3;
  localparam logic [3:0] OpCla = 4'd4;
  localparam logic [3:0] OpCle = 4'd5;
  localparam logic [3:0] OpCma = 4'd6;
  localparam logic [3:0] OpCme = 4'd7;
  localparam logic [3:0] OpCir = 4'd8;
  localparam logic [3:0] OpCil = 4'd9;
  localparam logic [3:0] OpInc = 4'd10;
`ifdef AC_MUL_EN
  localparam logic [3:0] OpMul = 4'd11;
  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);
`endif

  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StMul = 2'd2} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_ac, w_ac_nxt;
  logic             r_e, w_e_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_dr, w_dr_nxt;
  logic [WIDTH:0]   w_sum;
  logic             w_accept;
`ifdef AC_MUL_EN
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
`endif

  assign w_sum    = {1'b0, r_ac} + {1'b0, r_dr};
  // op_ready folds in reset so cu never sees a handshake while reset is low.
  assign bus.op_ready = reset & en & (r_state == StIdle);
  assign w_accept     = bus.op_valid & bus.op_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ac_nxt    = r_ac;
    w_e_nxt     = r_e;
    w_done_nxt  = 1'b0;
    w_op_nxt    = r_op;
    w_dr_nxt    = r_dr;
`ifdef AC_MUL_EN
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
`endif
    if (en) begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_op_nxt    = bus.opcode;
            w_dr_nxt    = bus.dr_data;
            w_state_nxt = StExec;
`ifdef AC_MUL_EN
            if (bus.opcode == OpMul) begin
              w_state_nxt = StMul;
              w_cnt_nxt   = '0;
              w_acc_nxt   = '0;
              w_mcand_nxt = {{WIDTH{1'b0}}, r_ac};
            end
`endif
          end
        end
        StExec: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
          case (r_op)
            OpAnd: w_ac_nxt = r_ac & r_dr;
            OpAdd: {w_e_nxt, w_ac_nxt} = w_sum;
            OpLda: w_ac_nxt = r_dr;
            OpCla: w_ac_nxt = '0;
            OpCle: w_e_nxt = 1'b0;
            OpCma: w_ac_nxt = ~r_ac;
            OpCme: w_e_nxt = ~r_e;
            OpCir: begin
              w_ac_nxt = {r_e, r_ac[WIDTH-1:1]};
              w_e_nxt  = r_ac[0];
            end
            OpCil: begin
              w_ac_nxt = {r_ac[WIDTH-2:0], r_e};
              w_e_nxt  = r_ac[WIDTH-1];
            end
            OpInc: w_ac_nxt = r_ac + WIDTH'(1);
            default: ;  // NOP, reserved opcodes
          endcase
        end
`ifdef AC_MUL_EN
        StMul: begin
          if (r_cnt != CntW'(MUL_CYCLES)) begin
            // r_dr shifts right to expose the next multiplier bit.
            if (r_dr[0]) w_acc_nxt = r_acc + r_mcand;
            w_mcand_nxt = r_mcand << 1;
            w_dr_nxt    = r_dr >> 1;
            w_cnt_nxt   = r_cnt + CntW'(1);
          end else begin
            w_ac_nxt    = r_acc[WIDTH-1:0];
            w_e_nxt     = |r_acc[2*WIDTH-1:WIDTH];
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
          end
        end
`endif
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_ac    <= '0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= '0;
      r_dr    <= '0;
`ifdef AC_MUL_EN
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ac    <= w_ac_nxt;
      r_e     <= w_e_nxt;
      r_done  <= w_done_nxt;
      r_op    <= w_op_nxt;
      r_dr    <= w_dr_nxt;
`ifdef AC_MUL_EN
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
`endif
    end
  end

  assign bus.ac_data = r_ac;
  assign bus.e_flag  = r_e;
  assign bus.ac_zero = (r_ac == '0);
  assign bus.ac_neg  = r_ac[WIDTH-1];
  assign bus.busy    = (r_state != StIdle);
  assign bus.done    = r_done;

endmodule

// File: tb/tb_ac_alu_unit.sv
// Directed self-checking bench for ac_alu_unit. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_ac_alu_unit;
  logic clk = 1'b0;
  logic reset;
  logic en;
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  ac_alu_unit_if #(.WIDTH(16)) bus ();

  ac_alu_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one op and measure edges from the accepting edge to done.
  task automatic do_op(input logic [3:0] op, input logic [15:0] d, input int exp_lat,
                       input string tag);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.opcode   = op;
    bus.dr_data  = d;
    chk({tag, "_ready"}, {31'd0, bus.op_ready}, 32'd1);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!bus.done && lat < 40);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    en           = 1'b1;
    bus.op_valid = 1'b0;
    bus.opcode   = 4'd0;
    bus.dr_data  = 16'h0000;
    #12;
    chk("rst_ac", bus.ac_data, 16'h0000);
    chk("rst_e", bus.e_flag, 1'b0);
    chk("rst_ready", bus.op_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // ADD carry out and zero flag
    do_op(4'd3, 16'hFFFF, 1, "lda_ffff");
    chk("lda_ac", bus.ac_data, 16'hFFFF);
    chk("lda_neg", bus.ac_neg, 1'b1);
    do_op(4'd2, 16'h0001, 1, "add_1");
    chk("add_ac", bus.ac_data, 16'h0000);
    chk("add_e", bus.e_flag, 1'b1);
    chk("add_zero", bus.ac_zero, 1'b1);

    // INC wraps, E untouched; CMA
    do_op(4'd3, 16'hFFFF, 1, "lda_ffff2");
    do_op(4'd10, 16'h0000, 1, "inc");
    chk("inc_ac", bus.ac_data, 16'h0000);
    chk("inc_e", bus.e_flag, 1'b1);
    do_op(4'd6, 16'h0000, 1, "cma");
    chk("cma_ac", bus.ac_data, 16'hFFFF);
    chk("cma_neg", bus.ac_neg, 1'b1);
    chk("cma_zero", bus.ac_zero, 1'b0);

    // Rotates through E
    do_op(4'd5, 16'h0000, 1, "cle");
    chk("cle_e", bus.e_flag, 1'b0);
    do_op(4'd3, 16'h8001, 1, "lda_8001");
    do_op(4'd9, 16'h0000, 1, "cil");
    chk("cil_ac", bus.ac_data, 16'h0002);
    chk("cil_e", bus.e_flag, 1'b1);
    do_op(4'd8, 16'h0000, 1, "cir1");
    chk("cir1_ac", bus.ac_data, 16'h8001);
    chk("cir1_e", bus.e_flag, 1'b0);
    do_op(4'd8, 16'h0000, 1, "cir2");
    chk("cir2_ac", bus.ac_data, 16'h4000);
    chk("cir2_e", bus.e_flag, 1'b1);
    do_op(4'd7, 16'h0000, 1, "cme");
    chk("cme_e", bus.e_flag, 1'b0);

    // AND, CLA, reserved opcode
    do_op(4'd3, 16'hF0F0, 1, "lda_f0f0");
    do_op(4'd1, 16'h3C3C, 1, "and");
    chk("and_ac", bus.ac_data, 16'h3030);
    do_op(4'd13, 16'hFFFF, 1, "op13");
    chk("op13_ac", bus.ac_data, 16'h3030);
    chk("op13_e", bus.e_flag, 1'b0);
    do_op(4'd4, 16'h0000, 1, "cla");
    chk("cla_ac", bus.ac_data, 16'h0000);

    // Stall in EXEC
    do_op(4'd3, 16'h0100, 1, "lda_0100");
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.opcode   = 4'd2;
    bus.dr_data  = 16'h0011;
    @(posedge clk);
    #1;
    en           = 1'b0;
    bus.opcode   = 4'd3;       // cu would present an LDA here; must not be taken
    bus.dr_data  = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_done", bus.done, 1'b0);
      chk("stall_ac", bus.ac_data, 16'h0100);
      chk("stall_ready", bus.op_ready, 1'b0);
      chk("stall_busy", bus.busy, 1'b1);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    en           = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_done", bus.done, 1'b1);
    chk("resume_ac", bus.ac_data, 16'h0111);
    chk("resume_e", bus.e_flag, 1'b0);
    @(posedge clk);
    #1;
    chk("resume_done_pulse", bus.done, 1'b0);
    chk("resume_ac_hold", bus.ac_data, 16'h0111);
    chk("resume_idle", bus.busy, 1'b0);

    // Asynchronous reset mid-operation
    do_op(4'd3, 16'h1234, 1, "lda_1234");
    do_op(4'd7, 16'h0000, 1, "cme2");
    chk("pre_rst_e", bus.e_flag, 1'b1);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.opcode   = 4'd2;
    bus.dr_data  = 16'h0001;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_ac", bus.ac_data, 16'h0000);
    chk("arst_e", bus.e_flag, 1'b0);
    chk("arst_ready", bus.op_ready, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_abort_ac", bus.ac_data, 16'h0000);
    chk("arst_abort_done", bus.done, 1'b0);

    // Opcode 11
`ifdef AC_MUL_EN
    do_op(4'd3, 16'h0100, 1, "lda_mul1");
    do_op(4'd11, 16'h0300, 17, "mul1");
    chk("mul1_ac", bus.ac_data, 16'h0000);
    chk("mul1_e", bus.e_flag, 1'b1);
    do_op(4'd3, 16'h0012, 1, "lda_mul2");
    do_op(4'd11, 16'h0003, 17, "mul2");
    chk("mul2_ac", bus.ac_data, 16'h0036);
    chk("mul2_e", bus.e_flag, 1'b0);
`else
    do_op(4'd3, 16'h5A5A, 1, "lda_5a5a");
    do_op(4'd7, 16'h0000, 1, "cme3");
    do_op(4'd11, 16'h0003, 1, "op11");
    chk("op11_ac", bus.ac_data, 16'h5A5A);
    chk("op11_e", bus.e_flag, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
